// File: rtl/fpu_pkg.sv
// Shared format constants, loader state encoding and conversion flag type
// for the FPU operand path (native format: sign[31], exp[30:25] bias 31, mant[24:0]).
package fpu_pkg;

   localparam int FPU_BIAS  = 31;
   localparam int IEEE_BIAS = 127;
   localparam int EXP_W     = 6;
   localparam int MANT_W    = 25;

   // IEEE exponent window that maps onto a nonzero native exponent field
   localparam logic [7:0] IEEE_EXP_OFS = 8'(IEEE_BIAS - FPU_BIAS);
   localparam logic [7:0] IEEE_EXP_LO  = 8'(IEEE_BIAS - FPU_BIAS + 1);
   localparam logic [7:0] IEEE_EXP_HI  = 8'(IEEE_BIAS + FPU_BIAS + 1);

   localparam logic [31:0] FPU_CANON_NAN = 32'h7F00_0000;

   typedef enum logic [2:0] {
      ST_LOAD_A,
      ST_CVT_A,
      ST_LOAD_B,
      ST_CVT_B,
      ST_PRESENT
   } loader_state_t;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
   } cvt_flags_t;

endpackage

// File: rtl/ieee_to_fpu_cvt.sv
// Combinational IEEE-754 single to native FPU format converter with fault flags.
// FPU_LOADER_SAT_EN selects saturation to the largest finite value on overflow.
module ieee_to_fpu_cvt
   import fpu_pkg::*;
(
   input  logic [31:0] ieee_i,
   output logic [31:0] fpu_o,
   output cvt_flags_t  flags_o
);

`ifdef FPU_LOADER_SAT_EN
   localparam logic [MANT_W-1:0] OVF_MANT = '1;
`else
   localparam logic [MANT_W-1:0] OVF_MANT = '0;
`endif

   logic              sign;
   logic [7:0]        exp_ieee;
   logic [22:0]       mant_ieee;
   logic [EXP_W-1:0]  exp_fpu;
   logic [31:0]       ovf_word;

   assign sign      = ieee_i[31];
   assign exp_ieee  = ieee_i[30:23];
   assign mant_ieee = ieee_i[22:0];
   assign exp_fpu   = EXP_W'(exp_ieee - IEEE_EXP_OFS);
   assign ovf_word  = {sign, {EXP_W{1'b1}}, OVF_MANT};

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      fpu_o   = {sign, 31'b0};
      flags_o = '0;
      if (exp_ieee == 8'd0) begin
         flags_o.underflow = (mant_ieee != '0);
      end else if (exp_ieee == 8'hFF) begin
         if (mant_ieee != '0) begin
            fpu_o           = FPU_CANON_NAN;
            flags_o.invalid = 1'b1;
         end else begin
            fpu_o            = ovf_word;
            flags_o.overflow = 1'b1;
         end
      end else if (exp_ieee < IEEE_EXP_LO) begin
         // Native exponent field 0 is reserved for zero, so tiny normals flush.
         flags_o.underflow = 1'b1;
      end else if (exp_ieee <= IEEE_EXP_HI) begin
         fpu_o = {sign, exp_fpu, mant_ieee, 2'b00};
      end else begin
         fpu_o            = ovf_word;
         flags_o.overflow = 1'b1;
      end
   end

endmodule

// File: rtl/fpu_operand_loader.sv
// Pairs IEEE operands A and B from a valid/ready stream, converts each to native
// format through one shared converter and presents the pair with sticky flags.
// Overflow result selected by FPU_LOADER_SAT_EN (see ieee_to_fpu_cvt).
module fpu_operand_loader
   import fpu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic [31:0] op_A_out,
   output logic [31:0] op_B_out,
   output logic        op_valid,
   input  logic        op_ready,
   output logic [2:0]  cvt_flags
);

   loader_state_t state_q, state_d;
   logic [31:0]   raw_q;
   logic [31:0]   op_a_q, op_a_d;
   logic [31:0]   op_b_q, op_b_d;
   cvt_flags_t    flags_q, flags_d;
   logic [31:0]   cvt_word;
   cvt_flags_t    cvt_fl;
   logic          xfer;

   ieee_to_fpu_cvt u_cvt (
      .ieee_i  (raw_q),
      .fpu_o   (cvt_word),
      .flags_o (cvt_fl)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_LOAD_A;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_LOAD_A:  if (xfer) state_d = ST_CVT_A;
         ST_CVT_A:   state_d = ST_LOAD_B;
         ST_LOAD_B:  if (xfer) state_d = ST_CVT_B;
         ST_CVT_B:   state_d = ST_PRESENT;
         ST_PRESENT: if (op_ready) state_d = ST_LOAD_A;
         default:    state_d = ST_LOAD_A;
      endcase
   end

   // in_ready is masked by reset so nothing is offered while reset is held.
   always_comb begin
      in_ready = !reset && (state_q == ST_LOAD_A || state_q == ST_LOAD_B);
      op_valid = (state_q == ST_PRESENT);
   end

   assign xfer = in_valid && in_ready;

   always_comb begin
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      flags_d = flags_q;
      unique case (state_q)
         ST_CVT_A: begin
            op_a_d  = cvt_word;
            flags_d = flags_q | cvt_fl;
         end
         ST_CVT_B: begin
            op_b_d  = cvt_word;
            flags_d = flags_q | cvt_fl;
         end
         ST_PRESENT: if (op_ready) flags_d = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         op_a_q  <= '0;
         op_b_q  <= '0;
         flags_q <= '0;
      end else begin
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         flags_q <= flags_d;
      end
   end

   // NOTE: raw_q has no reset; it is only read in CVT states, which always follow a transfer.
   always_ff @(posedge clock) begin
      if (xfer) raw_q <= in_data;
   end

   assign op_A_out  = op_a_q;
   assign op_B_out  = op_b_q;
   assign cvt_flags = flags_q;

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Self-checking bench for fpu_operand_loader: table of operand pairs with a
// scoreboard queue, plus hand-written back-pressure and mid-operation reset sequences.
module tb_fpu_operand_loader;
   import fpu_pkg::*;

`ifdef FPU_LOADER_SAT_EN
   localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
   localparam logic [31:0] OVF_NEG = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] OVF_POS = 32'h7E00_0000;
   localparam logic [31:0] OVF_NEG = 32'hFE00_0000;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic [31:0] op_A_out, op_B_out;
   logic        op_valid;
   logic        op_ready = 1'b0;
   logic [2:0]  cvt_flags;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [2:0]  exp_flags;
      int          hold;
      logic        ready_early;
   } vec_t;

   typedef struct {
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [2:0]  exp_flags;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[7];

   fpu_operand_loader dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .op_A_out  (op_A_out),
      .op_B_out  (op_B_out),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .cvt_flags (cvt_flags)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one word; the handshake edge is the first posedge with in_ready high.
   task automatic send(input logic [31:0] w);
      int n = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (!in_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("send_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_data  = 32'hDEAD_BEEF;
   endtask

   task automatic run_pair(input vec_t v);
      exp_t e;
      op_ready = v.ready_early;
      @(negedge clock);
      send(v.a);
      @(negedge clock);
      check("cvt_a_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clock);
      check("op_A_after_cvt", op_A_out, v.exp_a);
      check("load_b_in_ready", {31'b0, in_ready}, 32'd1);
      sb_q.push_back('{v.exp_a, v.exp_b, v.exp_flags});
      send(v.b);
      @(negedge clock);
      check("cvt_b_op_valid", {31'b0, op_valid}, 32'd0);
      @(negedge clock);
      check("present_op_valid", {31'b0, op_valid}, 32'd1);
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check("op_A", op_A_out, e.exp_a);
         check("op_B", op_B_out, e.exp_b);
         check("cvt_flags", {29'b0, cvt_flags}, {29'b0, e.exp_flags});
      end
      check("present_in_ready", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < v.hold; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h3F80_0000;
         @(negedge clock);
         check("hold_op_valid", {31'b0, op_valid}, 32'd1);
         check("hold_in_ready", {31'b0, in_ready}, 32'd0);
         check("hold_op_A", op_A_out, v.exp_a);
         check("hold_op_B", op_B_out, v.exp_b);
         check("hold_flags", {29'b0, cvt_flags}, {29'b0, v.exp_flags});
      end
      in_valid = 1'b0;
      op_ready = 1'b1;
      @(posedge clock);
      #1;
      op_ready = 1'b0;
      @(negedge clock);
      check("release_op_valid", {31'b0, op_valid}, 32'd0);
      check("release_flags", {29'b0, cvt_flags}, 32'd0);
      check("release_in_ready", {31'b0, in_ready}, 32'd1);
      check("release_op_A_kept", op_A_out, v.exp_a);
   endtask

   initial begin
      vecs[0] = '{32'h3F80_0000, 32'h4020_0000, 32'h3E00_0000, 32'h4080_0000, 3'b000, 0, 1'b1};
      vecs[1] = '{32'hBF80_0000, 32'h0000_0000, 32'hBE00_0000, 32'h0000_0000, 3'b000, 0, 1'b0};
      vecs[2] = '{32'h5000_0000, 32'h3F80_0000, OVF_POS,       32'h3E00_0000, 3'b010, 0, 1'b0};
      vecs[3] = '{32'h3000_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h7F00_0000, 3'b101, 5, 1'b0};
      vecs[4] = '{32'h3080_0000, 32'h4FFF_FFFF, 32'h0200_0000, 32'h7FFF_FFFC, 3'b000, 0, 1'b0};
      vecs[5] = '{32'h8000_0001, 32'hFF80_0000, 32'h8000_0000, OVF_NEG,       3'b011, 0, 1'b0};
      vecs[6] = '{32'hFFC0_0001, 32'h7F80_0000, 32'h7F00_0000, OVF_POS,       3'b110, 2, 1'b0};

      repeat (3) @(negedge clock);
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_op_valid", {31'b0, op_valid}, 32'd0);
      check("rst_op_A", op_A_out, 32'd0);
      check("rst_op_B", op_B_out, 32'd0);
      check("rst_flags", {29'b0, cvt_flags}, 32'd0);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      for (int i = 0; i < 7; i++) run_pair(vecs[i]);

      // Mid-operation reset: A (a NaN, so flags would be nonzero) is converted, then reset hits.
      @(negedge clock);
      send(32'h7FC0_0000);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clock);
      check("mid_rst_op_A", op_A_out, 32'd0);
      check("mid_rst_op_B", op_B_out, 32'd0);
      check("mid_rst_flags", {29'b0, cvt_flags}, 32'd0);
      check("mid_rst_op_valid", {31'b0, op_valid}, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("mid_rst_release_ready", {31'b0, in_ready}, 32'd1);
      run_pair(vecs[0]);
      run_pair(vecs[4]);

      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

endmodule
